// File: rtl/mips_pkg.sv
// Shared definitions for the instruction-memory responder:
// FSM state encoding, default reset/NOP word and index-width helper.
package mips_pkg;

    typedef enum logic [1:0] {
        IMEM_IDLE = 2'd0,
        IMEM_WAIT = 2'd1,
        IMEM_RESP = 2'd2
    } imem_state_t;

    localparam logic [31:0] IMEM_NOP_WORD = 32'h0000_0000;
    localparam int          IMEM_CNT_W    = 4;

    // Word-index width for a power-of-two depth; never below one bit.
    function automatic int imem_idx_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word store: synchronous write, asynchronous read.
// No reset; contents survive the responder being reset.
module imem_array
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned AW          = imem_idx_w(1024)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/imem_responder.sv
// Wait-state instruction memory answering IF-stage fetches with a one-cycle ready pulse.
// Optional one-entry last-word buffer enabled by defining IMEM_LINE_BUF_EN.
//
//   state     | meaning
//   IMEM_IDLE | waiting for req; req sampled only here
//   IMEM_WAIT | fetch accepted, counting wait states, stall high
//   IMEM_RESP | ready pulse visible; word was read at entry
module imem_responder
    import mips_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2,
    parameter logic [31:0] NOP_WORD    = IMEM_NOP_WORD
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [31:0] addr,
    input  logic        cancel,
    output logic        ready,
    output logic [31:0] instr,
    output logic        stall,
    output logic        addr_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int unsigned AW = imem_idx_w(DEPTH_WORDS);
    localparam logic [IMEM_CNT_W-1:0] WS = IMEM_CNT_W'(WAIT_STATES);

    imem_state_t           r_state, w_state_nx;
    logic [IMEM_CNT_W-1:0] r_cnt, w_cnt_nx;
    logic [AW-1:0]         r_idx, w_idx_nx;
    logic                  r_err, w_err_nx;
    logic                  r_ready, w_ready_nx;
    logic [31:0]           r_instr, w_instr_nx;
    logic                  r_stall, w_stall_nx;
    logic                  r_addr_err, w_aerr_nx;

    logic [AW-1:0] w_req_idx, w_ld_idx, w_rd_idx;
    logic          w_req_err, w_ld_ok, w_cur_err;
    logic [31:0]   w_rdata, w_buf_data;
    logic          w_hit, w_resp, w_fill;
    logic          w_unused_ld;

    assign w_req_idx   = addr[AW+1:2];
    assign w_req_err   = (addr[1:0] != 2'b00) || (addr[31:AW+2] != '0);
    assign w_ld_idx    = ld_addr[AW+1:2];
    assign w_ld_ok     = ld_en && (ld_addr[31:AW+2] == '0);
    assign w_unused_ld = ^ld_addr[1:0];

    // In IDLE the read serves a zero-wait response straight from the request.
    assign w_rd_idx  = (r_state == IMEM_IDLE) ? w_req_idx : r_idx;
    assign w_cur_err = (r_state == IMEM_IDLE) ? w_req_err : r_err;

    imem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_array (
        .clk    (clk),
        .i_we   (w_ld_ok),
        .i_waddr(w_ld_idx),
        .i_wdata(ld_data),
        .i_raddr(w_rd_idx),
        .o_rdata(w_rdata)
    );

`ifdef IMEM_LINE_BUF_EN
    logic          r_buf_valid;
    logic [AW-1:0] r_buf_tag;
    logic [31:0]   r_buf_data;
    logic          w_ld_hits_buf;

    assign w_ld_hits_buf = w_ld_ok && (w_ld_idx == r_buf_tag);
    // A write landing on the buffered word this edge makes the buffered copy stale.
    assign w_hit      = r_buf_valid && !w_req_err && (w_req_idx == r_buf_tag) && !w_ld_hits_buf;
    assign w_buf_data = r_buf_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_buf_valid <= 1'b0;
            r_buf_tag   <= '0;
            r_buf_data  <= NOP_WORD;
        end else begin
            if (w_fill) begin
                r_buf_valid <= 1'b1;
                r_buf_tag   <= w_rd_idx;
                r_buf_data  <= w_rdata;
            end
            if ((w_fill && w_ld_ok && (w_ld_idx == w_rd_idx)) || (!w_fill && w_ld_hits_buf)) begin
                r_buf_valid <= 1'b0;
            end
        end
    end
`else
    assign w_hit      = 1'b0;
    assign w_buf_data = NOP_WORD;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IMEM_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_err      <= 1'b0;
            r_ready    <= 1'b0;
            r_instr    <= NOP_WORD;
            r_stall    <= 1'b0;
            r_addr_err <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_idx      <= w_idx_nx;
            r_err      <= w_err_nx;
            r_ready    <= w_ready_nx;
            r_instr    <= w_instr_nx;
            r_stall    <= w_stall_nx;
            r_addr_err <= w_aerr_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_idx_nx   = r_idx;
        w_err_nx   = r_err;
        w_ready_nx = 1'b0;
        w_instr_nx = r_instr;
        w_stall_nx = 1'b0;
        w_aerr_nx  = r_addr_err;
        w_resp     = 1'b0;
        w_fill     = 1'b0;

        unique case (r_state)
            IMEM_IDLE: begin
                if (req) begin
                    w_idx_nx = w_req_idx;
                    w_err_nx = w_req_err;
                    w_cnt_nx = WS;
                    if (w_hit) begin
                        w_state_nx = IMEM_RESP;
                        w_ready_nx = 1'b1;
                        w_instr_nx = w_buf_data;
                        w_aerr_nx  = 1'b0;
                    end else if (WS == '0) begin
                        w_state_nx = IMEM_RESP;
                        w_resp     = 1'b1;
                    end else begin
                        w_state_nx = IMEM_WAIT;
                        w_stall_nx = 1'b1;
                    end
                end
            end
            IMEM_WAIT: begin
                // Branch flush outranks counter expiry.
                if (cancel) begin
                    w_state_nx = IMEM_IDLE;
                    w_cnt_nx   = '0;
                end else if (r_cnt == IMEM_CNT_W'(1)) begin
                    w_state_nx = IMEM_RESP;
                    w_cnt_nx   = '0;
                    w_resp     = 1'b1;
                end else begin
                    w_cnt_nx   = r_cnt - IMEM_CNT_W'(1);
                    w_stall_nx = 1'b1;
                end
            end
            IMEM_RESP: begin
                w_state_nx = IMEM_IDLE;
            end
            default: begin
                w_state_nx = IMEM_IDLE;
            end
        endcase

        if (w_resp) begin
            w_ready_nx = 1'b1;
            w_aerr_nx  = w_cur_err;
            w_instr_nx = w_cur_err ? NOP_WORD : w_rdata;
            w_fill     = !w_cur_err;
        end
    end

    assign ready    = r_ready;
    assign instr    = r_instr;
    assign stall    = r_stall;
    assign addr_err = r_addr_err;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a timeline-based model.
module tb_imem_responder;

    localparam int          DEPTH = 64;
    localparam int          WS    = 2;
    localparam logic [31:0] NOP   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        cancel = 1'b0;
    logic        ld_en = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;
    logic        ready, stall, addr_err;
    logic [31:0] instr;

    imem_responder #(
        .DEPTH_WORDS(DEPTH),
        .WAIT_STATES(WS),
        .NOP_WORD   (NOP)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .addr    (addr),
        .cancel  (cancel),
        .ready   (ready),
        .instr   (instr),
        .stall   (stall),
        .addr_err(addr_err),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model: fetch timeline by edge number ----------------
    logic [31:0] m_mem [DEPTH];
    logic        m_ready = 1'b0;
    logic        m_stall = 1'b0;
    logic        m_err   = 1'b0;
    logic [31:0] m_instr = NOP;
    bit          f_active = 1'b0;
    int          f_due    = 0;
    logic [31:0] f_addr   = '0;
    int          free_at  = 0;
    int          edge_n   = 0;
    bit          b_valid  = 1'b0;
    logic [31:0] b_tag    = '0;
    logic [31:0] b_data   = '0;

    function automatic bit bad_addr(input logic [31:0] a);
        return (a[1:0] != 2'b00) || ((a >> 2) >= 32'(DEPTH));
    endfunction

    task automatic respond(input logic [31:0] a);
        m_ready = 1'b1;
        if (bad_addr(a)) begin
            m_instr = NOP;
            m_err   = 1'b1;
        end else begin
            m_instr = m_mem[a[31:2]];
            m_err   = 1'b0;
`ifdef IMEM_LINE_BUF_EN
            b_valid = 1'b1;
            b_tag   = a >> 2;
            b_data  = m_instr;
`endif
        end
        f_active = 1'b0;
        free_at  = edge_n + 2;
    endtask

    always @(posedge clk) begin
        bit hit;
        edge_n++;
        if (!rst) begin
            f_active = 1'b0;
            free_at  = 0;
            b_valid  = 1'b0;
            m_ready  = 1'b0;
            m_err    = 1'b0;
            m_instr  = NOP;
        end else begin
            m_ready = 1'b0;
            if (f_active && cancel && edge_n <= f_due) begin
                f_active = 1'b0;
                free_at  = edge_n + 1;
            end else if (f_active && edge_n == f_due) begin
                respond(f_addr);
            end else if (!f_active && edge_n >= free_at && req) begin
                hit = b_valid && !bad_addr(addr) && ((addr >> 2) == b_tag)
                      && !(ld_en && ((ld_addr >> 2) == b_tag));
                if (hit) begin
                    m_ready = 1'b1;
                    m_instr = b_data;
                    m_err   = 1'b0;
                    free_at = edge_n + 2;
                end else if (WS == 0) begin
                    respond(addr);
                end else begin
                    f_active = 1'b1;
                    f_due    = edge_n + WS;
                    f_addr   = addr;
                end
            end
        end
        // Writes land regardless of fetch state; reads above saw the pre-edge contents.
        if (ld_en && ((ld_addr >> 2) < 32'(DEPTH))) begin
            m_mem[ld_addr[31:2]] = ld_data;
            if ((ld_addr >> 2) == b_tag) b_valid = 1'b0;
        end
        m_stall = f_active;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cmp_ready", ready, m_ready);
            chk("cmp_stall", stall, m_stall);
            chk("cmp_addr_err", addr_err, m_err);
            chk("cmp_instr", instr, m_instr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic fetch_lit(input string name, input logic [31:0] a, input logic [31:0] exp_instr,
                             input logic exp_err, input int lat);
        req  = 1'b1;
        addr = a;
        for (int i = 1; i <= lat; i++) begin
            step();
            req = 1'b0;
            chk({name, "_ready"}, ready, 32'(i == lat));
            chk({name, "_stall"}, stall, 32'(i < lat));
        end
        chk({name, "_instr"}, instr, exp_instr);
        chk({name, "_err"}, addr_err, 32'(exp_err));
        step();
        chk({name, "_tail"}, ready, 32'd0);
    endtask

    initial begin
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", ready, 32'd0);
        chk("rst_stall", stall, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_err", addr_err, 32'd0);
        @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        chk_en = 1'b1;

        for (int i = 0; i < DEPTH; i++) begin
            step();
            ld_en   = 1'b1;
            ld_addr = 32'(i * 4);
            ld_data = $urandom;
        end
        step(); ld_addr = 32'h10; ld_data = 32'h8C22_0004;
        step(); ld_addr = 32'h14; ld_data = 32'h1234_5678;
        step(); ld_en = 1'b0;

        // basic fetch, then error fetches
        fetch_lit("t1", 32'h10, 32'h8C22_0004, 1'b0, WS + 1);
        chk("pin_model_instr", m_instr, 32'h8C22_0004);
        fetch_lit("t2_misaligned", 32'h12, NOP, 1'b1, WS + 1);
        chk("pin_model_err", 32'(m_err), 32'd1);
        fetch_lit("t2_range", 32'(DEPTH * 4), NOP, 1'b1, WS + 1);

        // cancel mid-wait, next request accepted right away
        req = 1'b1; addr = 32'h20;
        step(); req = 1'b0; cancel = 1'b1;
        chk("t3_stall_c1", stall, 32'd1);
        step(); cancel = 1'b0;
        chk("t3_stall_c2", stall, 32'd0);
        chk("t3_ready_c2", ready, 32'd0);
        fetch_lit("t3_next", 32'h14, 32'h1234_5678, 1'b0, WS + 1);

        // reset in the middle of a wait
        req = 1'b1; addr = 32'h14;
        step(); req = 1'b0;
        chk("t4_stall", stall, 32'd1);
        step();
        #2 rst = 1'b0;
        #1;
        chk("t4_rst_ready", ready, 32'd0);
        chk("t4_rst_stall", stall, 32'd0);
        chk("t4_rst_instr", instr, 32'd0);
        chk("t4_rst_err", addr_err, 32'd0);
        step();
        #2 rst = 1'b1;
        step();
        fetch_lit("t4_after", 32'h14, 32'h1234_5678, 1'b0, WS + 1);

        // write to the in-flight word before response
        req = 1'b1; addr = 32'h30;
        step(); req = 1'b0; ld_en = 1'b1; ld_addr = 32'h30; ld_data = 32'hDEAD_BEEF;
        step(); ld_en = 1'b0;
        step();
        chk("t5_ready", ready, 32'd1);
        chk("t5_instr", instr, 32'hDEAD_BEEF);
        step();
        chk("t5_tail", ready, 32'd0);

`ifdef IMEM_LINE_BUF_EN
        fetch_lit("t6_fill", 32'h10, 32'h8C22_0004, 1'b0, WS + 1);
        fetch_lit("t6_hit", 32'h10, 32'h8C22_0004, 1'b0, 1);
        ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'hCAFE_F00D;
        step(); ld_en = 1'b0;
        fetch_lit("t6_reload", 32'h10, 32'hCAFE_F00D, 1'b0, WS + 1);
`else
        fetch_lit("t6_first", 32'h10, 32'h8C22_0004, 1'b0, WS + 1);
        fetch_lit("t6_again", 32'h10, 32'h8C22_0004, 1'b0, WS + 1);
`endif

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            step();
            req = ($urandom_range(0, 1) == 1);
            case ($urandom_range(0, 9))
                0: addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
                1: addr = 32'(DEPTH * 4) + (32'($urandom_range(0, 255)) << 2);
                2: addr = $urandom;
                default: addr = 32'($urandom_range(0, 15)) << 2;
            endcase
            cancel  = ($urandom_range(0, 7) == 0);
            ld_en   = ($urandom_range(0, 5) == 0);
            ld_addr = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            ld_data = $urandom;
            if ($urandom_range(0, 399) == 0) begin
                #2 rst = 1'b0;
                step();
                #2 rst = 1'b1;
            end
        end
        step();
        req = 1'b0; cancel = 1'b0; ld_en = 1'b0;
        repeat (6) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
